// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART word receiver.
package uart_rx_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } rx_state_e;

  // Width of a counter that must hold values 0..max_val (never less than 1 bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer: mid-bit (half) and end-of-bit (full) strobes, restartable by the FSM.
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 443
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic restart_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam int CW = cnt_w(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt_q, clk_cnt_d;

  assign half_tick_o = (clk_cnt_q == HALF_LAST);
  assign full_tick_o = (clk_cnt_q == FULL_LAST);

  // Free-runs and wraps each bit period so consecutive data bits need no restart.
  always_comb begin
    clk_cnt_d = clk_cnt_q + CW'(1);
    if (restart_i || full_tick_o) clk_cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) clk_cnt_q <= '0;
    else          clk_cnt_q <= clk_cnt_d;
  end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// 8N1 UART receiver that gathers NUM_BYTES frames into one word and offers it on valid/ready.
module uart_rx_word_assembler
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 443,
  parameter int NUM_BYTES    = 12,
  parameter int DATA_W       = 8 * NUM_BYTES,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic              CLK_I,
  input  logic              RSTL_I,
  input  logic              UART_RX_I,
  input  logic              WORD_READY_I,
  output logic              WORD_VALID_O,
  output logic [DATA_W-1:0] WORD_DATA_O,
  output logic              FRAME_ERR_O,
  output logic              OVERRUN_O,
  output logic              TIMEOUT_O
);

  localparam int BYTE_W   = cnt_w(NUM_BYTES - 1);
  localparam int BIT_W    = cnt_w(BITS_PER_BYTE - 1);
  localparam int GAP_LAST = (TIMEOUT_BITS > 0) ? TIMEOUT_BITS * CLKS_PER_BIT - 1 : 0;
  localparam int GAP_W    = cnt_w(GAP_LAST);

  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(BITS_PER_BYTE - 1);
  localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(GAP_LAST);

  logic rx_meta_q, rx_s_q;

  rx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic [DATA_W-1:0] word_data_q, word_data_d;
  logic              word_valid_q, word_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic timer_restart, half_tick, full_tick;
  logic word_done, load, accept;

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i      (CLK_I),
    .rst_n_i    (RSTL_I),
    .restart_i  (timer_restart),
    .half_tick_o(half_tick),
    .full_tick_o(full_tick)
  );

  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX_I;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = '0;
    stage_d       = stage_q;
    timer_restart = 1'b0;
    word_done     = 1'b0;
    frame_err_d   = 1'b0;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        timer_restart = 1'b1;
        if (!rx_s_q) begin
          state_d = START;
        end else if ((TIMEOUT_BITS > 0) && (byte_cnt_q != '0)) begin
          // Staging is left as is: the next NUM_BYTES frames shift it out completely.
          if (gap_cnt_q == GAP_END) begin
            byte_cnt_d = '0;
            timeout_d  = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end

      START: begin
        if (half_tick) begin
          if (!rx_s_q) begin
            state_d       = DATA;
            bit_cnt_d     = '0;
            timer_restart = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (full_tick) begin
          // LSB-first shift-in leaves byte 0 bit 0 at bit 0 once the word is full.
          stage_d = {rx_s_q, stage_q[DATA_W-1:1]};
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
          else                       bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      STOP: begin
        if (full_tick) begin
          if (rx_s_q) begin
            state_d = IDLE;
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              word_done  = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            end
          end else begin
            state_d       = RECOVER;
            byte_cnt_d    = '0;
            frame_err_d   = 1'b1;
            timer_restart = 1'b1;
          end
        end
      end

      RECOVER: begin
        // A full bit period of continuous high is required before hunting for a start bit.
        if (!rx_s_q)        timer_restart = 1'b1;
        else if (full_tick) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign accept = word_valid_q && WORD_READY_I;
  assign load   = word_done && (!word_valid_q || WORD_READY_I);

  always_comb begin
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    overrun_d    = word_done && !load;
    if (load) begin
      word_valid_d = 1'b1;
      word_data_d  = stage_q;
    end else if (accept) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  always_ff @(posedge CLK_I) begin
    stage_q <= stage_d;
  end

  assign WORD_VALID_O = word_valid_q;
  assign WORD_DATA_O  = word_data_q;
  assign FRAME_ERR_O  = frame_err_q;
  assign OVERRUN_O    = overrun_q;
  assign TIMEOUT_O    = timeout_q;

endmodule
